// File: rtl/issue_sched_if.sv
// Handshake bundle between a reservation station (master) and its issue scheduler (slave).
`ifndef XLEN
`define XLEN 32
`endif

interface issue_sched_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = 4,
    parameter int unsigned AGEW = `XLEN
);
    localparam int unsigned CNTW = 16;

    logic [N-1:0]            req;
    logic [N-1:0][AGEW-1:0]  age;
    logic                    flush;
    logic                    fu_ready;
    logic [N-1:0]            gnt;
    logic                    issue_valid;
    logic [IDXW-1:0]         issue_idx;
    logic [AGEW-1:0]         issue_age;
    logic [CNTW-1:0]         issue_cnt;

    modport master (
        output req, age, flush, fu_ready,
        input  gnt, issue_valid, issue_idx, issue_age, issue_cnt
    );

    modport slave (
        input  req, age, flush, fu_ready,
        output gnt, issue_valid, issue_idx, issue_age, issue_cnt
    );
endinterface

// File: rtl/issue_sched.sv
// Oldest-first issue scheduler: picks the oldest ready RS entry into a one-deep
// registered issue slot that drains into a functional unit.
`ifndef XLEN
`define XLEN 32
`endif

module issue_sched #(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = 4,
    parameter int unsigned AGEW = `XLEN
) (
    input  logic         clock,
    input  logic         reset_n,
    issue_sched_if.slave bus
);
    localparam int unsigned CNTW = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [AGEW-1:0] age_q, age_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            sel_valid;
    logic [IDXW-1:0] sel_idx;
    logic [AGEW-1:0] sel_age;
    logic            load_c;
    logic            drain_c;

    // Oldest requester wins; strict compare keeps ties on the lowest index.
    // Ages of idle entries are never looked at, so unknowns there cannot leak.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                if (!sel_valid || (bus.age[i] < sel_age)) begin
                    sel_valid = 1'b1;
                    sel_idx   = IDXW'(i);
                    sel_age   = bus.age[i];
                end
            end
        end
    end

    assign drain_c = (state_q == FULL) && bus.fu_ready && !bus.flush;
    assign load_c  = reset_n && !bus.flush && sel_valid &&
                     ((state_q == EMPTY) || bus.fu_ready);

    assign bus.gnt = load_c ? (N'(1) << sel_idx) : '0;

    // Slot state, payload and accepted-issue counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        age_d   = age_q;
        cnt_d   = cnt_q;

        if (drain_c) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        if (bus.flush) begin
            state_d = EMPTY;
        end else if (load_c) begin
            state_d = FULL;
            idx_d   = sel_idx;
            age_d   = sel_age;
        end else if (drain_c) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            age_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            age_q   <= age_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.issue_valid = (state_q == FULL);
    assign bus.issue_idx   = idx_q;
    assign bus.issue_age   = age_q;
    assign bus.issue_cnt   = cnt_q;

    gnt_onehot_a: assert property (@(posedge clock) $onehot0(bus.gnt));
    gnt_flush_a:  assert property (@(posedge clock) bus.flush |-> (bus.gnt == '0));
    gnt_reset_a:  assert property (@(posedge clock) !reset_n |-> (bus.gnt == '0));

endmodule

// File: tb/tb_issue_sched.sv
// Scoreboard bench for issue_sched: grants and drained issues checked against a reference model.
module tb_issue_sched;
    localparam int unsigned N    = 16;
    localparam int unsigned IDXW = 4;
    localparam int unsigned AGEW = 8;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [AGEW-1:0] age;
    } ent_t;

    logic                   clock;
    logic                   reset_n;
    logic [N-1:0]           req;
    logic [N-1:0][AGEW-1:0] age;
    logic                   flush;
    logic                   fu_ready;

    issue_sched_if #(.N(N), .IDXW(IDXW), .AGEW(AGEW)) bus ();

    assign bus.req      = req;
    assign bus.age      = age;
    assign bus.flush    = flush;
    assign bus.fu_ready = fu_ready;

    issue_sched #(.N(N), .IDXW(IDXW), .AGEW(AGEW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        sb_q[$];
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner is the requester that no other requester beats on (age, index).
    function automatic int pick_oldest();
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
                bit beaten = 1'b0;
                for (int j = 0; j < int'(N); j++) begin
                    if (req[j] && j != i &&
                        ((age[j] < age[i]) || (age[j] == age[i] && j < i)))
                        beaten = 1'b1;
                end
                if (!beaten) return i;
            end
        end
        return -1;
    endfunction

    // One clock: check outputs mid-cycle, advance the model, then let the RS free granted entries.
    task automatic step();
        logic [N-1:0] eg;
        int           w;
        logic         ld;
        logic         dr;
        ent_t         e;

        @(negedge clock);
        w  = pick_oldest();
        ld = reset_n && !flush && (req != '0) && (!m_valid || fu_ready);
        eg = '0;
        if (ld && w >= 0) eg[w] = 1'b1;

        check("gnt", 64'(bus.gnt), 64'(eg));
        check("issue_valid", 64'(bus.issue_valid), 64'(m_valid));
        check("issue_cnt", 64'(bus.issue_cnt), 64'(m_cnt));
        if (m_valid && sb_q.size() > 0) begin
            check("held_idx", 64'(bus.issue_idx), 64'(sb_q[0].idx));
            check("held_age", 64'(bus.issue_age), 64'(sb_q[0].age));
        end

        dr = m_valid && fu_ready && !flush;
        if (!reset_n) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_cnt   = '0;
        end else begin
            if (dr && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("drain_idx", 64'(bus.issue_idx), 64'(e.idx));
                check("drain_age", 64'(bus.issue_age), 64'(e.age));
                m_cnt = m_cnt + 16'd1;
            end
            if (flush) begin
                sb_q.delete();
                m_valid = 1'b0;
            end else if (ld) begin
                e.idx = IDXW'(w);
                e.age = age[w];
                sb_q.push_back(e);
                m_valid = 1'b1;
            end else if (dr) begin
                m_valid = 1'b0;
            end
        end

        @(posedge clock);
        #1;
        req = req & ~eg;
    endtask

    initial begin
        int guard;

        reset_n  = 1'b0;
        req      = '1;
        age      = '0;
        flush    = 1'b0;
        fu_ready = 1'b1;
        m_valid  = 1'b0;
        m_cnt    = '0;

        // Reset: no grants while held, outputs cleared.
        step();
        step();
        check("rst_idx", 64'(bus.issue_idx), 64'd0);
        check("rst_age", 64'(bus.issue_age), 64'd0);

        // Oldest pick; idle entries carry age 0 which must be ignored.
        reset_n  = 1'b1;
        fu_ready = 1'b0;
        req      = 16'h0011;
        age      = '0;
        age[0]   = AGEW'(40);
        age[4]   = AGEW'(12);
        step();
        check("oldest_idx", 64'(bus.issue_idx), 64'd4);
        check("oldest_age", 64'(bus.issue_age), 64'd12);
        req      = '0;
        step();
        fu_ready = 1'b1;
        step();

        // Tie goes to the lower index.
        req      = 16'h0300;
        age[8]   = AGEW'(7);
        age[9]   = AGEW'(7);
        step();
        check("tie_idx", 64'(bus.issue_idx), 64'd8);
        req      = '0;
        step();

        // Backpressure: held entry is not replaced by an older request.
        fu_ready = 1'b0;
        req      = 16'h0008;
        age[3]   = AGEW'(50);
        step();
        req      = 16'h8000;
        age[15]  = AGEW'(0);
        for (int k = 0; k < 3; k++) step();
        check("bp_hold_idx", 64'(bus.issue_idx), 64'd3);
        fu_ready = 1'b1;
        step();
        check("bp_new_idx", 64'(bus.issue_idx), 64'd15);
        req      = '0;
        step();

        // Streaming: three issues back-to-back, then empty.
        req      = 16'h0070;
        age[4]   = AGEW'(5);
        age[5]   = AGEW'(3);
        age[6]   = AGEW'(9);
        for (int k = 0; k < 5; k++) step();

        // Flush squashes the held issue without counting it.
        fu_ready = 1'b0;
        req      = 16'h0002;
        age[1]   = AGEW'(20);
        step();
        flush    = 1'b1;
        fu_ready = 1'b1;
        req      = 16'h000F;
        step();
        flush    = 1'b0;
        req      = '0;
        step();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 3) req = '0;
            else req = N'($urandom);
            for (int i = 0; i < int'(N); i++) age[i] = AGEW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 9) == 0);
            fu_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        flush    = 1'b0;
        fu_ready = 1'b1;
        req      = '0;
        step();

        // Stream up to the counter wrap point.
        age[0] = AGEW'(1);
        guard  = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            req = 16'h0001;
            step();
            guard++;
        end
        check("cnt_at_max", 64'(bus.issue_cnt), 64'hFFFF);
        req = '0;
        step();
        check("cnt_wrap", 64'(bus.issue_cnt), 64'h0000);

        // Reset while FULL discards the held issue.
        fu_ready = 1'b0;
        req      = 16'h0020;
        age[5]   = AGEW'(33);
        step();
        check("pre_rst_valid", 64'(bus.issue_valid), 64'd1);
        reset_n  = 1'b0;
        step();
        check("rst2_valid", 64'(bus.issue_valid), 64'd0);
        check("rst2_idx", 64'(bus.issue_idx), 64'd0);
        check("rst2_age", 64'(bus.issue_age), 64'd0);
        check("rst2_cnt", 64'(bus.issue_cnt), 64'd0);
        reset_n  = 1'b1;
        req      = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
